// File: rtl/reg8_write_arbiter_if.sv
// Requester handshakes, stall and register-side outputs of the shared reg8 write arbiter.
// master = requester/test side, slave = arbiter.
interface reg8_write_arbiter_if;
  logic       req0_val;
  logic       req0_rdy;
  logic [7:0] req0_data;
  logic       req1_val;
  logic       req1_rdy;
  logic [7:0] req1_data;
  logic       stall;
  logic       reg_en;
  logic [7:0] reg_d;
  logic       last_grant;
  logic [7:0] wr_count;

  modport master (
    output req0_val, req0_data, req1_val, req1_data, stall,
    input  req0_rdy, req1_rdy, reg_en, reg_d, last_grant, wr_count
  );

  modport slave (
    input  req0_val, req0_data, req1_val, req1_data, stall,
    output req0_rdy, req1_rdy, reg_en, reg_d, last_grant, wr_count
  );
endinterface

// File: rtl/reg8_write_arbiter.sv
// Round-robin arbiter staging one byte per cycle into a shared 8-bit enable register; en/d one cycle after accept.
// Backpressure: rdy is combinational on val, held low by stall or reset; a byte already staged always writes.
module reg8_write_arbiter (
  input logic                 clk,
  input logic                 rst,
  reg8_write_arbiter_if.slave bus
);
  logic       ptr;
  logic       stage_valid;
  logic [7:0] stage_data;
  logic       last_grant_q;
  logic [7:0] wr_count_q;
  logic       grant0;
  logic       grant1;

  // Contention goes to ptr; a lone valid requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && !bus.stall) begin
      if (bus.req0_val && (!bus.req1_val || !ptr)) begin
        grant0 = 1'b1;
      end else if (bus.req1_val) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_rdy   = grant0;
  assign bus.req1_rdy   = grant1;
  assign bus.reg_en     = stage_valid;
  assign bus.reg_d      = stage_data;
  assign bus.last_grant = last_grant_q;
  assign bus.wr_count   = wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr          <= 1'b0;
      stage_valid  <= 1'b0;
      stage_data   <= 8'h00;
      last_grant_q <= 1'b0;
      wr_count_q   <= 8'h00;
    end else begin
      stage_valid <= grant0 | grant1;
      if (grant0) begin
        ptr          <= 1'b1;
        last_grant_q <= 1'b0;
        stage_data   <= bus.req0_data;
      end else if (grant1) begin
        ptr          <= 1'b0;
        last_grant_q <= 1'b1;
        stage_data   <= bus.req1_data;
      end
      if (stage_valid) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Bench for reg8_write_arbiter: reference model plus write scoreboard, with per-scenario tasks.
module tb_reg8_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  reg8_write_arbiter_if bus();

  reg8_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared enable register driven by reg_en/reg_d.
  logic [7:0] q = 8'h00;
  initial forever begin
    @(posedge clk);
    if (bus.reg_en === 1'b1) q = bus.reg_d;
  end

  // Reference model: ptr, last grant, write count, and staged bytes awaiting their write cycle.
  logic       mptr   = 1'b0;
  logic       mlast  = 1'b0;
  logic [7:0] mcount = 8'h00;
  logic [7:0] exp_q[$];

  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (rst === 1'b1 && bus.stall === 1'b0) begin
      if (bus.req0_val && bus.req1_val) g = mptr ? 2'b10 : 2'b01;
      else if (bus.req0_val)            g = 2'b01;
      else if (bus.req1_val)            g = 2'b10;
    end
    return g;
  endfunction

  initial forever begin
    logic [1:0] g;
    @(posedge clk);
    if (rst !== 1'b1) begin
      mptr = 1'b0;
      mlast = 1'b0;
      mcount = 8'h00;
      exp_q.delete();
    end else begin
      g = model_grant();
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        mcount = mcount + 8'd1;
      end
      if (g[0]) begin
        exp_q.push_back(bus.req0_data);
        mptr = 1'b1;
        mlast = 1'b0;
      end else if (g[1]) begin
        exp_q.push_back(bus.req1_data);
        mptr = 1'b0;
        mlast = 1'b1;
      end
    end
  end

  // Scoreboard compare on every falling edge.
  initial forever begin
    logic [1:0] eg;
    logic       een;
    @(negedge clk);
    eg  = model_grant();
    een = (exp_q.size() > 0);
    vectors++;
    if ({bus.req1_rdy, bus.req0_rdy} !== eg) begin
      miscompares++;
      $display("FAIL sb_rdy t=%0t: got %b want %b", $time, {bus.req1_rdy, bus.req0_rdy}, eg);
    end
    vectors++;
    if (bus.reg_en !== een) begin
      miscompares++;
      $display("FAIL sb_reg_en t=%0t: got %b want %b", $time, bus.reg_en, een);
    end
    if (een) begin
      vectors++;
      if (bus.reg_d !== exp_q[0]) begin
        miscompares++;
        $display("FAIL sb_reg_d t=%0t: got %h want %h", $time, bus.reg_d, exp_q[0]);
      end
    end
    vectors++;
    if (bus.wr_count !== mcount) begin
      miscompares++;
      $display("FAIL sb_wr_count t=%0t: got %h want %h", $time, bus.wr_count, mcount);
    end
    vectors++;
    if (bus.last_grant !== mlast) begin
      miscompares++;
      $display("FAIL sb_last_grant t=%0t: got %b want %b", $time, bus.last_grant, mlast);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_val  = 1'b0;
    bus.req1_val  = 1'b0;
    bus.req0_data = 8'h00;
    bus.req1_data = 8'h00;
    bus.stall     = 1'b0;
  endtask

  task automatic quick_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.req0_val = 1'b1;
    bus.req1_val = 1'b1;
    bus.req0_data = 8'hFF;
    bus.req1_data = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_rdy: got %b%b want 00", bus.req1_rdy, bus.req0_rdy);
      end
      tick();
    end
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (bus.reg_en !== 1'b0 || bus.reg_d !== 8'h00 || bus.wr_count !== 8'h00 || bus.last_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got en=%b d=%h cnt=%h lg=%b want en=0 d=00 cnt=00 lg=0",
               bus.reg_en, bus.reg_d, bus.wr_count, bus.last_grant);
    end
    tick();
  endtask

  task automatic test_single();
    bus.req0_val  = 1'b1;
    bus.req0_data = 8'hA5;
    @(negedge clk);
    vectors++;
    if (bus.req0_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rdy: got %b want 1", bus.req0_rdy);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if (bus.reg_en !== 1'b1 || bus.reg_d !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_write: got en=%b d=%h want en=1 d=a5", bus.reg_en, bus.reg_d);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (q !== 8'hA5 || bus.wr_count !== 8'h01) begin
      miscompares++;
      $display("FAIL single_q: got q=%h cnt=%h want q=a5 cnt=01", q, bus.wr_count);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want_g[4];
    logic [7:0] want_d[4];
    want_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    want_d = '{8'h11, 8'h22, 8'h11, 8'h22};
    quick_reset();
    bus.req0_val  = 1'b1;
    bus.req1_val  = 1'b1;
    bus.req0_data = 8'h11;
    bus.req1_data = 8'h22;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle_inputs();
      @(negedge clk);
      if (i < 4) begin
        vectors++;
        if ({bus.req1_rdy, bus.req0_rdy} !== want_g[i]) begin
          miscompares++;
          $display("FAIL contention_grant%0d: got %b want %b", i, {bus.req1_rdy, bus.req0_rdy}, want_g[i]);
        end
      end
      if (i > 0) begin
        vectors++;
        if (bus.reg_en !== 1'b1 || bus.reg_d !== want_d[i-1]) begin
          miscompares++;
          $display("FAIL contention_d%0d: got en=%b d=%h want en=1 d=%h", i - 1, bus.reg_en, bus.reg_d, want_d[i-1]);
        end
      end
      tick();
    end
    vectors++;
    if (bus.last_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL contention_last_grant: got %b want 1", bus.last_grant);
    end
  endtask

  task automatic test_stall();
    bus.req0_val  = 1'b1;
    bus.req0_data = 8'h77;
    @(negedge clk);
    vectors++;
    if (bus.req0_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_pre_rdy: got %b want 1", bus.req0_rdy);
    end
    tick();
    bus.req1_val  = 1'b1;
    bus.req1_data = 8'h88;
    bus.stall     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_rdy%0d: got %b%b want 00", i, bus.req1_rdy, bus.req0_rdy);
      end
      vectors++;
      if (bus.reg_en !== (i == 0) || (i == 0 && bus.reg_d !== 8'h77)) begin
        miscompares++;
        $display("FAIL stall_write%0d: got en=%b d=%h want en=%0d d=77", i, bus.reg_en, bus.reg_d, (i == 0));
      end
      tick();
    end
    bus.stall = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus.req1_rdy, bus.req0_rdy} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_resume_grant: got %b want 10", {bus.req1_rdy, bus.req0_rdy});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_mid_reset();
    bus.req1_val  = 1'b1;
    bus.req1_data = 8'h5A;
    tick();
    idle_inputs();
    bus.req0_val  = 1'b1;
    bus.req0_data = 8'h3C;
    @(negedge clk);
    vectors++;
    if (bus.req0_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_rdy: got %b want 1", bus.req0_rdy);
    end
    #1 rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req0_val  = 1'b1;
    bus.req1_val  = 1'b1;
    bus.req0_data = 8'h01;
    bus.req1_data = 8'h02;
    @(negedge clk);
    vectors++;
    if (bus.reg_en !== 1'b0 || bus.wr_count !== 8'h00 || q !== 8'h5A) begin
      miscompares++;
      $display("FAIL midrst_state: got en=%b cnt=%h q=%h want en=0 cnt=00 q=5a", bus.reg_en, bus.wr_count, q);
    end
    vectors++;
    if ({bus.req1_rdy, bus.req0_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_ptr: got %b want 01", {bus.req1_rdy, bus.req0_rdy});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int run = 0;
    quick_reset();
    for (int i = 0; i < 256; i++) begin
      bus.req0_val  = 1'b1;
      bus.req0_data = 8'(i * 7 + 3);
      @(negedge clk);
      if (i > 0 && bus.reg_en === 1'b1) run++;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    if (bus.reg_en === 1'b1) run++;
    vectors++;
    if (run !== 256) begin
      miscompares++;
      $display("FAIL wrap_run: got %0d want 256", run);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.wr_count !== 8'h00 || bus.reg_en !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_count: got cnt=%h en=%b want cnt=00 en=0", bus.wr_count, bus.reg_en);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg8_write_arbiter.md
# reg8_write_arbiter

Round-robin write arbiter and sequencer that shares one 8-bit enable register (the team's DFF-with-reset-and-enable register) between two requesters. Each requester offers a byte over a val/rdy handshake. The arbiter picks at most one per cycle, stages the byte for one cycle, then drives the register's `en`/`d` pins. It also keeps a grant history and a wrap-around write counter for debug and test visibility.

## Interface
Parameters: none; data width fixed at 8 bits.
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets all state
- req0_val  input  1  requester 0 has a valid byte
- req0_rdy  output  1  arbiter accepts requester 0 this cycle
- req0_data  input  8  requester 0 byte
- req1_val  input  1  requester 1 has a valid byte
- req1_rdy  output  1  arbiter accepts requester 1 this cycle
- req1_data  input  8  requester 1 byte
- stall  input  1  1 = accept no new transfers this cycle
- reg_en  output  1  drives register `en`
- reg_d  output  8  drives register `d`
- last_grant  output  1  index of the most recently accepted requester
- wr_count  output  8  number of writes issued to the register, modulo 256

## Operation
- Transfer on requester i: reqi_val & reqi_rdy in the same cycle. At most one transfer per cycle.
- Priority pointer `ptr` (1 bit) names the favoured requester.
- Grant (combinational), qualified by rst=1 and stall=0:
  - only req0_val=1: grant 0
  - only req1_val=1: grant 1
  - both valid: grant ptr
  - neither valid: no grant
- reqi_rdy = grant==i. rdy never asserts while stall=1 or rst=0. rdy may depend combinationally on val.
- On a transfer from requester i:
  - ptr <= ~i, so the other requester is favoured next
  - last_grant <= i
  - staging register <= reqi_data
  - stage_valid <= 1
- With no transfer, stage_valid <= 0. ptr and last_grant hold.
- reg_en = stage_valid. reg_d = staging register. Both come from flops, not combinational logic.
- wr_count increments by 1 on each cycle with reg_en=1. 255 wraps to 0.
- stall blocks only new acceptances. A byte already staged is still written on the next cycle.
- Simultaneous valids held for k cycles give alternating grants starting at the current ptr. Neither requester waits more than one cycle while the other is continuously valid.
- A requester must hold val and data stable until rdy. The arbiter does not check this.

## Timing
- Reset (rst=0 at an edge): ptr=0, last_grant=0, stage_valid=0, staging=8'h00, wr_count=0.
- Hence after reset: reg_en=0, reg_d=8'h00, wr_count=8'h00, last_grant=0.
- Combinational req*_rdy outputs are 0 while rst=0.
- Latency:
  - transfer in cycle N
  - reg_en=1 and reg_d=data in cycle N+1
  - register q shows data from cycle N+2
  - wr_count shows +1 from cycle N+2
- Throughput: one write per cycle. Back-to-back transfers give reg_en held high with reg_d changing each cycle.
- Reset mid-operation: a staged byte is discarded. reg_en is 0 in the cycle after the reset edge and no write is issued. The pointer returns to requester 0.
- stall=1 in cycle N blocks a transfer in cycle N only. A transfer in N-1 still produces reg_en=1 in N.

## Test plan
- Reset: hold rst=0 for 2 cycles with both val=1. Required: both rdy=0 throughout, then reg_en=0, reg_d=00, wr_count=00, last_grant=0.
- Single requester: req0_val=1 with data A5 for one cycle. Required: req0_rdy=1 that cycle; reg_en=1 and reg_d=A5 the next cycle; register q=A5 and wr_count=01 the cycle after.
- Contention: both val=1 for 4 cycles after reset, data0=11 and data1=22. Required: grants 0,1,0,1; reg_d sequence 11,22,11,22 on consecutive cycles; last_grant ends at 1.
- Stall: both val=1, stall=1 for 2 cycles then 0. Required: no rdy during stall; a byte staged before the stall still writes; the first grant after the stall goes to the current ptr.
- Reset mid-operation: transfer 3C in cycle N with rst=0 at the edge ending N. Required: reg_en=0 in N+1, q unchanged, wr_count=00, ptr=0.
- Counter wrap: 256 back-to-back single-requester transfers. Required: wr_count returns to 00 and reg_en stays 1 for 256 consecutive cycles.
